cmd_serializer: RTL and testbench

Bit-level transmitter for the SD card CMD line. It steps the byte pointer through the combinational CMD packet multiplexor, loads each returned byte, and shifts it out MSB-first on SD clock strobes. While sending the header and argument bytes it computes CRC7 and feeds that value back to the multiplexor, which uses it to form the CRC byte. It sits directly downstream of the CMD packet multiplexor and upstream of the CMD pad driver and the response receiver.

---
 rtl/sd_cmd_pkg.sv | 19 +
 rtl/cmd_serializer_if.sv | 25 ++
 rtl/crc7_bit.sv | 16 +
 rtl/cmd_serializer.sv | 124 ++++++++++++
 tb/tb_cmd_serializer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line transmit path: FSM encoding,
// CRC7 polynomial, CRC byte position and default packet geometry.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FIN
  } state_t;

  // x^7 + x^3 + 1, the implicit x^7 term dropped
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int CRC_BYTE_IDX   = 5;
  localparam int DEF_PKTBYTES   = 6;
  localparam int DEF_TRAILBYTES = 1;

endpackage

// File: rtl/cmd_serializer_if.sv
// Signal bundle between the CMD serializer, its packet multiplexor,
// the SD clock strobe source and the CMD pad driver.
interface cmd_serializer_if;

  logic       clken;
  logic       start;
  logic [7:0] muxbyte;
  logic [4:0] ptcmdpntr;
  logic [7:0] crc7;
  logic       cmd;
  logic       cmdoe;
  logic       busy;
  logic       done;

  modport master (
    input  clken, start, muxbyte,
    output ptcmdpntr, crc7, cmd, cmdoe, busy, done
  );

  modport slave (
    output clken, start, muxbyte,
    input  ptcmdpntr, crc7, cmd, cmdoe, busy, done
  );

endinterface

// File: rtl/crc7_bit.sv
// One-bit CRC7 step; purely combinational so the data-line logic can
// chain or reuse it as needed.
module crc7_bit
  import sd_cmd_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic       bit_in,
  output logic [6:0] crc_out
);

  logic fb;

  assign fb      = bit_in ^ crc_in[6];
  assign crc_out = {crc_in[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);

endmodule

// File: rtl/cmd_serializer.sv
// Walks the CMD packet multiplexor byte by byte and shifts each byte out
// MSB-first on SD clock strobes, accumulating CRC7 over header and argument.
module cmd_serializer
  import sd_cmd_pkg::*;
#(
  parameter int PKTBYTES   = DEF_PKTBYTES,
  parameter int TRAILBYTES = DEF_TRAILBYTES
) (
  input  logic                    clk,
  input  logic                    rst,
  cmd_serializer_if.master        bus
);

  localparam logic [4:0] LAST_PTR = 5'(PKTBYTES + TRAILBYTES - 1);
  localparam logic [4:0] CRC_PTR  = 5'(CRC_BYTE_IDX);

  state_t     state_reg,  state_next;
  logic [4:0] ptr_reg,    ptr_next;
  logic [6:0] crc_reg,    crc_next;
  logic [7:0] shreg_reg,  shreg_next;
  logic [2:0] bitcnt_reg, bitcnt_next;
  logic       cmd_reg,    cmd_next;
  logic       cmdoe_reg,  cmdoe_next;
  logic       done_reg,   done_next;

  logic [6:0] crc_upd;
  logic       shift_en;
  logic       last_bit;

  crc7_bit u_crc7_bit (
    .crc_in  (crc_reg),
    .bit_in  (shreg_reg[7]),
    .crc_out (crc_upd)
  );

  // a strobe landing in LOAD is a spacing violation and is simply ignored
  assign shift_en = (state_reg == ST_SHIFT) && bus.clken;
  assign last_bit = (bitcnt_reg == 3'd7);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      crc_reg    <= '0;
      shreg_reg  <= '0;
      bitcnt_reg <= '0;
      cmd_reg    <= 1'b1;
      cmdoe_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      crc_reg    <= crc_next;
      shreg_reg  <= shreg_next;
      bitcnt_reg <= bitcnt_next;
      cmd_reg    <= cmd_next;
      cmdoe_reg  <= cmdoe_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (bus.start) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_SHIFT;
      ST_SHIFT: if (shift_en && last_bit)
                  state_next = (ptr_reg == LAST_PTR) ? ST_FIN : ST_LOAD;
      ST_FIN:   if (bus.clken) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_next    = ptr_reg;
    crc_next    = crc_reg;
    shreg_next  = shreg_reg;
    bitcnt_next = bitcnt_reg;
    cmd_next    = cmd_reg;
    cmdoe_next  = cmdoe_reg;
    done_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          ptr_next    = '0;
          crc_next    = '0;
          bitcnt_next = '0;
        end
      end
      ST_LOAD: shreg_next = bus.muxbyte;
      ST_SHIFT: begin
        if (shift_en) begin
          cmd_next    = shreg_reg[7];
          cmdoe_next  = 1'b1;
          shreg_next  = {shreg_reg[6:0], 1'b0};
          bitcnt_next = bitcnt_reg + 3'd1;
          // CRC covers header and argument only; it is frozen for the CRC byte
          if (ptr_reg < CRC_PTR)
            crc_next = crc_upd;
          if (last_bit && (ptr_reg != LAST_PTR)) begin
            ptr_next    = ptr_reg + 5'd1;
            bitcnt_next = '0;
          end
        end
      end
      ST_FIN: begin
        if (bus.clken) begin
          cmd_next   = 1'b1;
          cmdoe_next = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.ptcmdpntr = ptr_reg;
  assign bus.crc7      = {1'b0, crc_reg};
  assign bus.cmd       = cmd_reg;
  assign bus.cmdoe     = cmdoe_reg;
  assign bus.done      = done_reg;
  assign bus.busy      = (state_reg != ST_IDLE) || done_reg;

endmodule

// File: tb/tb_cmd_serializer.sv
// Scoreboard bench for cmd_serializer: directed SD commands, expected line
// bytes queued at issue time and compared by an independent line monitor.
module tb_cmd_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clken = 1'b0;
  logic start = 1'b0;
  logic [7:0] pkt [0:7];
  logic irregular = 1'b0;
  int   fixed_gap = 3;

  int total = 0;
  int bad = 0;
  int bits_seen = 0;
  int done_cnt = 0;
  int pkt_bytes = 0;
  int bitn = 0;
  int exp_dones = 0;

  logic [7:0] exp_q [$];
  logic [7:0] crc_q [$];

  cmd_serializer_if bus();

  assign bus.clken = clken;
  assign bus.start = start;
  // packet multiplexor model: argument bytes, then CRC byte, then idle 0xFF
  assign bus.muxbyte = (bus.ptcmdpntr < 5'd5) ? pkt[bus.ptcmdpntr[2:0]] :
                       (bus.ptcmdpntr == 5'd5) ? {bus.crc7[6:0], 1'b1} : 8'hFF;

  cmd_serializer #(
    .PKTBYTES   (6),
    .TRAILBYTES (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // SD clock strobe generator: fixed spacing or a 2/5/17 cycle pattern
  int pat [0:2] = '{2, 5, 17};
  initial begin
    int pi = 0;
    int g;
    forever begin
      @(negedge clk); clken = 1'b1;
      @(negedge clk); clken = 1'b0;
      g = irregular ? pat[pi] : fixed_gap;
      pi = (pi + 1) % 3;
      repeat (g - 2) @(negedge clk);
    end
  end

  // line monitor
  logic       prev_cmd = 1'b1;
  logic       prev_oe = 1'b0;
  logic [7:0] acc = 8'h00;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bitn = 0;
      pkt_bytes = 0;
    end else begin
      if (!clken) begin
        check("hold_cmd", 32'(bus.cmd), 32'(prev_cmd));
        check("hold_cmdoe", 32'(bus.cmdoe), 32'(prev_oe));
      end
      if (clken && bus.cmdoe) begin
        if (bitn == 0) check("ptr_seq", 32'(bus.ptcmdpntr), 32'(pkt_bytes));
        acc = {acc[6:0], bus.cmd};
        bitn++;
        bits_seen++;
        if (bitn == 8) begin
          bitn = 0;
          pkt_bytes++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_byte: got %0h expected none", acc);
          end else begin
            check("line_byte", 32'(acc), 32'(exp_q.pop_front()));
          end
        end
      end
      if (bus.done) begin
        if (crc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_done: got done expected none");
        end else begin
          check("done_crc7", 32'(bus.crc7), 32'(crc_q.pop_front()));
        end
        check("done_bytes", 32'(pkt_bytes), 32'd7);
        check("done_cmd", 32'(bus.cmd), 32'd1);
        check("done_cmdoe", 32'(bus.cmdoe), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd1);
        pkt_bytes = 0;
        bitn = 0;
        done_cnt++;
      end
    end
    prev_cmd = bus.cmd;
    prev_oe = bus.cmdoe;
  end

  task automatic send(input logic [39:0] args, input logic [7:0] crcb,
                      input logic [7:0] crcv, input bit at_edge);
    for (int i = 0; i < 5; i++) begin
      pkt[i] = args[39 - 8*i -: 8];
      exp_q.push_back(args[39 - 8*i -: 8]);
    end
    exp_q.push_back(crcb);
    exp_q.push_back(8'hFF);
    crc_q.push_back(crcv);
    if (!at_edge) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    check("crc_cleared", 32'(bus.crc7), 32'd0);
    check("ptr_cleared", 32'(bus.ptcmdpntr), 32'd0);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(posedge clk); #2;
      n++;
    end while (!bus.done && n < 3000);
    total++;
    if (!bus.done) begin
      bad++;
      $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
    end
  endtask

  task automatic wait_until_bits(input int target);
    int n = 0;
    while (bits_seen < target && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    total++;
    if (bits_seen < target) begin
      bad++;
      $display("FAIL bits_timeout: got %0d expected %0d", bits_seen, target);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pkt[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ptr", 32'(bus.ptcmdpntr), 32'd0);
    check("rst_crc7", 32'(bus.crc7), 32'd0);
    check("rst_cmd", 32'(bus.cmd), 32'd1);
    check("rst_cmdoe", 32'(bus.cmdoe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // CMD0, CMD17 and CMD8 with hand-computed CRCs
    send(40'h40_00_00_00_00, 8'h95, 8'h4A, 1'b0); wait_done("cmd0");  exp_dones++;
    repeat (5) @(negedge clk);
    send(40'h51_00_00_00_00, 8'h55, 8'h2A, 1'b0); wait_done("cmd17"); exp_dones++;
    repeat (5) @(negedge clk);
    send(40'h48_00_00_01_AA, 8'h87, 8'h43, 1'b0); wait_done("cmd8");  exp_dones++;
    repeat (5) @(negedge clk);

    // START while busy at byte 2 must be ignored
    send(40'h40_00_00_00_00, 8'h95, 8'h4A, 1'b0);
    begin
      int n = 0;
      while (pkt_bytes < 2 && n < 3000) begin @(posedge clk); #2; n++; end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("busy_start"); exp_dones++;
    repeat (100) @(negedge clk);
    check("no_second_packet", 32'(done_cnt), 32'(exp_dones));
    check("idle_busy", 32'(bus.busy), 32'd0);

    // reset after the 20th bit of a CMD17
    bits_seen = 0;
    send(40'h51_00_00_00_00, 8'h55, 8'h2A, 1'b0);
    wait_until_bits(20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cmd", 32'(bus.cmd), 32'd1);
    check("midrst_cmdoe", 32'(bus.cmdoe), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_ptr", 32'(bus.ptcmdpntr), 32'd0);
    check("midrst_crc7", 32'(bus.crc7), 32'd0);
    exp_q.delete();
    crc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(40'h40_00_00_00_00, 8'h95, 8'h4A, 1'b1); wait_done("post_rst"); exp_dones++;
    repeat (5) @(negedge clk);

    // irregular strobe spacing
    irregular = 1'b1;
    send(40'h40_00_00_00_00, 8'h95, 8'h4A, 1'b0); wait_done("irregular"); exp_dones++;
    irregular = 1'b0;
    repeat (5) @(negedge clk);

    // back-to-back: second START lands in the DONE cycle
    send(40'h48_00_00_01_AA, 8'h87, 8'h43, 1'b0); wait_done("b2b_first");  exp_dones++;
    send(40'h40_00_00_00_00, 8'h95, 8'h4A, 1'b0); wait_done("b2b_second"); exp_dones++;

    repeat (50) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("crc_q_empty", 32'(crc_q.size()), 32'd0);
    check("done_count", 32'(done_cnt), 32'(exp_dones));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
